// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: bundles the decode-side, forwarding, pipeline-control and
// ALU-side signals of the ID/EX pipeline register.
//   master : upstream/environment side (drives decode fields, forwarding
//            sources, flush/hold; observes stall and EX outputs)
//   slave  : the id_ex_stage itself
// Parameters: XLEN datapath width, RADDR register index width.
interface id_ex_stage_if #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
);
  // decode slot
  logic             id_valid;
  logic [XLEN-1:0]  id_rs_val;
  logic [XLEN-1:0]  id_rt_val;
  logic [XLEN-1:0]  id_imm;
  logic [4:0]       id_shamt;
  logic [RADDR-1:0] id_rs;
  logic [RADDR-1:0] id_rt;
  logic [RADDR-1:0] id_rd;
  logic [5:0]       id_op;
  logic             id_use_imm;
  logic             id_shift_imm;
  logic             id_uses_rt;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_mem_write;
  // forwarding sources
  logic             exmem_reg_write;
  logic [RADDR-1:0] exmem_rd;
  logic [XLEN-1:0]  exmem_result;
  logic             memwb_reg_write;
  logic [RADDR-1:0] memwb_rd;
  logic [XLEN-1:0]  memwb_result;
  // pipeline control
  logic             flush;
  logic             hold;
  logic             stall;
  // EX side
  logic [XLEN-1:0]  alu_a;
  logic [XLEN-1:0]  alu_b;
  logic [5:0]       alu_op;
  logic [XLEN-1:0]  ex_store_data;
  logic [RADDR-1:0] ex_rd;
  logic             ex_valid;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             ex_mem_write;

  modport master (
    output id_valid, id_rs_val, id_rt_val, id_imm, id_shamt, id_rs, id_rt,
           id_rd, id_op, id_use_imm, id_shift_imm, id_uses_rt, id_reg_write,
           id_mem_read, id_mem_write, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result, flush, hold,
    input  stall, alu_a, alu_b, alu_op, ex_store_data, ex_rd, ex_valid,
           ex_reg_write, ex_mem_read, ex_mem_write
  );

  modport slave (
    input  id_valid, id_rs_val, id_rt_val, id_imm, id_shamt, id_rs, id_rt,
           id_rd, id_op, id_use_imm, id_shift_imm, id_uses_rt, id_reg_write,
           id_mem_read, id_mem_write, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result, flush, hold,
    output stall, alu_a, alu_b, alu_op, ex_store_data, ex_rd, ex_valid,
           ex_reg_write, ex_mem_read, ex_mem_write
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU.
//   - captures decoded operands/control, forwards rs/rt from EX/MEM
//     (priority) or MEM/WB, selects ALU a/b, detects load-use hazards
//     (inserting one bubble), and obeys flush > hold > stall > capture.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      id_ex_stage_if.slave (decode, forwarding, control, EX outputs)
//   perf_bubbles / perf_flushes  saturating event counters, present only
//            when the macro ID_EX_PERF_CNT_EN is defined
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  id_ex_stage_if.slave bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0] perf_bubbles,
  output logic [31:0] perf_flushes
`endif
);

  logic             valid_reg;
  logic [5:0]       op_reg;
  logic [RADDR-1:0] rd_reg;
  logic [RADDR-1:0] src_idx_reg [2];  // [0]=rs, [1]=rt
  logic [XLEN-1:0]  src_val_reg [2];
  logic [XLEN-1:0]  imm_reg;
  logic [4:0]       shamt_reg;
  logic             use_imm_reg;
  logic             shift_imm_reg;
  logic             reg_write_reg;
  logic             mem_read_reg;
  logic             mem_write_reg;

  logic [XLEN-1:0]  fwd_val [2];
  logic             load_use;

  // Forwarding muxes; register 0 is hard-wired and never forwarded.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd_val[gi] = src_val_reg[gi];
        if (bus.exmem_reg_write && (bus.exmem_rd == src_idx_reg[gi]) &&
            (src_idx_reg[gi] != '0))
          fwd_val[gi] = bus.exmem_result;
        else if (bus.memwb_reg_write && (bus.memwb_rd == src_idx_reg[gi]) &&
                 (src_idx_reg[gi] != '0))
          fwd_val[gi] = bus.memwb_result;
      end
    end
  endgenerate

  // A load in EX cannot forward to the instruction currently in decode.
  assign load_use = valid_reg && mem_read_reg && (rd_reg != '0) &&
                    bus.id_valid &&
                    ((bus.id_rs == rd_reg) ||
                     (bus.id_uses_rt && (bus.id_rt == rd_reg)));

  assign bus.stall         = load_use && !bus.flush;
  assign bus.alu_a         = shift_imm_reg ? {{(XLEN-5){1'b0}}, shamt_reg}
                                           : fwd_val[0];
  assign bus.alu_b         = use_imm_reg ? imm_reg : fwd_val[1];
  assign bus.ex_store_data = fwd_val[1];
  assign bus.alu_op        = op_reg;
  assign bus.ex_rd         = rd_reg;
  assign bus.ex_valid      = valid_reg;
  assign bus.ex_reg_write  = reg_write_reg && valid_reg;
  assign bus.ex_mem_read   = mem_read_reg  && valid_reg;
  assign bus.ex_mem_write  = mem_write_reg && valid_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_reg      <= 1'b0;
      op_reg         <= '0;
      rd_reg         <= '0;
      src_idx_reg[0] <= '0;
      src_idx_reg[1] <= '0;
      src_val_reg[0] <= '0;
      src_val_reg[1] <= '0;
      imm_reg        <= '0;
      shamt_reg      <= '0;
      use_imm_reg    <= 1'b0;
      shift_imm_reg  <= 1'b0;
      reg_write_reg  <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
    end else if (bus.flush || (!bus.hold && load_use)) begin
      // flush kills the slot; a load-use stall inserts a bubble
      valid_reg     <= 1'b0;
      reg_write_reg <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
    end else if (bus.hold) begin
      // Refresh stored operands so a result retiring from MEM/WB during
      // the freeze is still seen once the hold releases.
      src_val_reg[0] <= fwd_val[0];
      src_val_reg[1] <= fwd_val[1];
    end else begin
      valid_reg      <= bus.id_valid;
      op_reg         <= bus.id_op;
      rd_reg         <= bus.id_rd;
      src_idx_reg[0] <= bus.id_rs;
      src_idx_reg[1] <= bus.id_rt;
      src_val_reg[0] <= bus.id_rs_val;
      src_val_reg[1] <= bus.id_rt_val;
      imm_reg        <= bus.id_imm;
      shamt_reg      <= bus.id_shamt;
      use_imm_reg    <= bus.id_use_imm;
      shift_imm_reg  <= bus.id_shift_imm;
      reg_write_reg  <= bus.id_reg_write;
      mem_read_reg   <= bus.id_mem_read;
      mem_write_reg  <= bus.id_mem_write;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubbles_reg;
  logic [31:0] flushes_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bubbles_reg <= '0;
      flushes_reg <= '0;
    end else if (!bus.hold) begin
      if (!bus.flush && load_use && (bubbles_reg != 32'hFFFF_FFFF))
        bubbles_reg <= bubbles_reg + 32'd1;
      if (bus.flush && valid_reg && (flushes_reg != 32'hFFFF_FFFF))
        flushes_reg <= flushes_reg + 32'd1;
    end
  end

  assign perf_bubbles = bubbles_reg;
  assign perf_flushes = flushes_reg;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU. Captures decoded operands and control from decode and drives the ALU's a, b and operation inputs.
- Contains the operand forwarding muxes from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts bubbles.
- Honours branch flush and downstream hold.

Parameters:
- XLEN, 32, datapath width.
- RADDR, 5, register index width.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_rs_val  in  XLEN  register-file rs read value
- id_rt_val  in  XLEN  register-file rt read value
- id_imm  in  XLEN  sign/zero-extended immediate
- id_shamt  in  5  shift amount field
- id_rs  in  RADDR  rs index
- id_rt  in  RADDR  rt index
- id_rd  in  RADDR  destination index (already rd/rt selected)
- id_op  in  6  ALU operation code
- id_use_imm  in  1  b = immediate
- id_shift_imm  in  1  a = shamt
- id_uses_rt  in  1  instruction reads rt
- id_reg_write  in  1  decode control: register write
- id_mem_read  in  1  decode control: memory read
- id_mem_write  in  1  decode control: memory write
- exmem_reg_write  in  1  EX/MEM forwarding source: write enable
- exmem_rd  in  RADDR  EX/MEM forwarding source: destination index
- exmem_result  in  XLEN  EX/MEM forwarding source: result
- memwb_reg_write  in  1  MEM/WB forwarding source: write enable
- memwb_rd  in  RADDR  MEM/WB forwarding source: destination index
- memwb_result  in  XLEN  MEM/WB forwarding source: result
- flush  in  1  branch taken; kill slot contents
- hold  in  1  downstream busy; freeze stage
- stall  out  1  load-use stall to fetch/decode (combinational)
- alu_a  out  XLEN  forwarded ALU operand a (combinational from registers)
- alu_b  out  XLEN  forwarded ALU operand b (combinational from registers)
- alu_op  out  6  registered operation code
- ex_store_data  out  XLEN  forwarded rt value for stores
- ex_rd  out  RADDR  registered destination index
- ex_valid  out  1  registered valid
- ex_reg_write  out  1  registered control, qualified by ex_valid
- ex_mem_read  out  1  registered control, qualified by ex_valid
- ex_mem_write  out  1  registered control, qualified by ex_valid

Behaviour:
- Reset, reset_n=0 at clk edge:
  - All registers cleared: ex_valid=0, alu_op=6'b000000, ex_rd=0, all control 0, stored operands 0.
  - stall=0 while ex_valid=0.
- Forwarding, combinational on registered indices:
  - For each of rs and rt: if exmem_reg_write and exmem_rd==idx and idx!=0, use exmem_result.
  - Else if memwb_reg_write and memwb_rd==idx and idx!=0, use memwb_result.
  - Else use the stored value. EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded.
- Operand selection:
  - alu_a = {27'b0, shamt} if shift_imm, else fwd_rs.
  - alu_b = imm if use_imm, else fwd_rt.
  - ex_store_data = fwd_rt always.
- Load-use detection:
  - stall=1 when all of the following hold: ex_valid, ex_mem_read, ex_rd!=0, id_valid, and (id_rs==ex_rd or (id_uses_rt and id_rt==ex_rd)).
  - stall is forced to 0 when flush=1.
- Next-state priority, per edge:
  1. reset.
  2. flush: ex_valid<=0, controls<=0. Flush beats hold and stall.
  3. hold: all fields retained. The stored rs/rt values are overwritten with the current forwarded values, so a retiring MEM/WB result is not lost. stall output still computed.
  4. stall: bubble, ex_valid<=0, controls<=0. Decode is expected to hold its inputs.
  5. Normal: capture all id_* fields; ex_valid<=id_valid.
- Latency: 1 cycle from decode to ALU inputs. A load followed by a dependent instruction costs exactly 1 bubble.
- ex_reg_write, ex_mem_read and ex_mem_write are 0 whenever ex_valid=0, regardless of captured values.
- Reset asserted mid-hold or mid-stall clears immediately at the next edge. No residual bubble follows.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_bubbles[31:0]: increments on each cycle a load-use bubble is inserted.
  - perf_flushes[31:0]: increments on each cycle flush=1 and ex_valid was 1.
- Both counters saturate at 32'hFFFFFFFF, clear on reset, and do not count while hold=1.
- When undefined, the ports and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset: hold reset_n=0 for 2 edges with id_valid=1 -> ex_valid=0, alu_op=0, ex_reg_write=0, stall=0.
- EX/MEM forwarding: capture id_rs=5, id_rs_val=32'h1; drive exmem_reg_write=1, exmem_rd=5, exmem_result=32'hAA and memwb_rd=5, memwb_result=32'hBB -> alu_a=32'hAA. With exmem_reg_write=0 -> alu_a=32'hBB.
- Register 0: stored rs=0, value 32'h0; exmem_rd=0, exmem_reg_write=1, exmem_result=32'hFFFF -> alu_a=0.
- Load-use: ex holds lw with ex_rd=8; id has add with id_rt=8, id_uses_rt=1 -> stall=1. Next edge ex_valid=0. Following edge the add is captured and stall=0.
- Flush priority: flush=1, hold=1, stall condition true -> next ex_valid=0, stall=0 during flush.
- Hold refresh: hold=1 for 2 cycles, memwb_rd=rs with result 32'h55 for the first cycle only -> after release alu_a=32'h55. With ID_EX_PERF_CNT_EN, one load-use bubble -> perf_bubbles=1.
